// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for the pipelined LC-3b datapath.
//
// Keeps the fetch PC and issues word reads to the instruction memory. At most
// one read is outstanding at a time. Returned words enter a 2-entry FIFO of
// {instr, pc}, and the FIFO head is offered to decode.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   imem_address      word-aligned fetch address (bit 0 always 0)
//   imem_read         read request, held high until imem_resp
//   imem_resp         one-cycle response strobe, imem_rdata valid with it
//   imem_rdata        returned instruction word
//   redirect          one-cycle strobe: flush buffered work, refetch
//   redirect_pc       new fetch target (bit 0 forced to 0)
//   dec_ready         decode accepts the head instruction this cycle
//   dec_valid         FIFO head holds a valid instruction
//   dec_instr         head instruction word
//   dec_pc            address of the head instruction
//   dec_pc_plus2      dec_pc + 2, wrapping at 16 bits
//
// Handshake: decode takes the head in any cycle where dec_valid & dec_ready
// are both high. While dec_valid is high and dec_ready is low, every dec_*
// output holds its value. A redirect in the same cycle cancels the transfer.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_address,
   output logic        imem_read,
   input  logic        imem_resp,
   input  logic [15:0] imem_rdata,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        dec_ready,
   output logic        dec_valid,
   output logic [15:0] dec_instr,
   output logic [15:0] dec_pc,
   output logic [15:0] dec_pc_plus2
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   localparam logic [15:0] RESET_ADDR = {RESET_PC[15:1], 1'b0};

   logic [1:0]  state;
   logic [15:0] fetch_pc;
   logic [15:0] req_addr;
   logic [15:0] redirect_addr;

   logic [15:0] buf_instr [2];
   logic [15:0] buf_pc    [2];
   logic        head;
   logic        tail;
   logic [1:0]  count;
   logic [1:0]  count_next;
   logic        push;
   logic        pop;

   assign redirect_addr = {redirect_pc[15:1], 1'b0};

   // A redirect beats both push and pop: the returned word and the head
   // instruction are both thrown away in that cycle.
   assign push = (state == FETCH) & imem_resp & ~redirect;
   assign pop  = dec_valid & dec_ready & ~redirect;

   always_comb begin
      count_next = count;
      if (redirect) begin
         count_next = 2'd0;
      end else if (push & ~pop) begin
         count_next = count + 2'd1;
      end else if (pop & ~push) begin
         count_next = count - 2'd1;
      end
   end

   // Fetch FSM. req_addr freezes the address of the request in flight so a
   // redirect can retarget fetch_pc while the old request is still drained
   // in DROP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_ADDR;
         req_addr <= RESET_ADDR;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  fetch_pc <= redirect_addr;
               end else if (count_next < 2'd2) begin
                  state    <= FETCH;
                  req_addr <= fetch_pc;
               end
            end
            FETCH: begin
               if (imem_resp) begin
                  state    <= IDLE;
                  fetch_pc <= redirect ? redirect_addr : fetch_pc + 16'd2;
               end else if (redirect) begin
                  state    <= DROP;
                  fetch_pc <= redirect_addr;
               end
            end
            DROP: begin
               if (redirect) begin
                  fetch_pc <= redirect_addr;
               end
               if (imem_resp) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Instruction FIFO. Entries reset to zero so the dec_* outputs come out
   // of reset as instr=0, pc=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_instr[0] <= 16'd0;
         buf_instr[1] <= 16'd0;
         buf_pc[0]    <= 16'd0;
         buf_pc[1]    <= 16'd0;
         head         <= 1'b0;
         tail         <= 1'b0;
         count        <= 2'd0;
      end else begin
         count <= count_next;
         if (redirect) begin
            head <= 1'b0;
            tail <= 1'b0;
         end else begin
            if (push) begin
               buf_instr[tail] <= imem_rdata;
               buf_pc[tail]    <= req_addr;
               tail            <= ~tail;
            end
            if (pop) begin
               head <= ~head;
            end
         end
      end
   end

   assign imem_read    = (state != IDLE);
   assign imem_address = (state == IDLE) ? fetch_pc : req_addr;

   assign dec_valid    = (count != 2'd0);
   assign dec_instr    = buf_instr[head];
   assign dec_pc       = buf_pc[head];
   assign dec_pc_plus2 = buf_pc[head] + 16'd2;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
//
// A memory model answers each request after a chosen latency with a word that
// is a fixed function of its address. The reference model tracks the program
// order the front end should follow (next request address, queue of words
// that decode should see) and is flushed by redirects and reset.
module tb_fetch_unit;

   localparam logic [15:0] RST_PC = 16'h3000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_address;
   logic        imem_read;
   logic        imem_resp;
   logic [15:0] imem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        dec_ready;
   logic        dec_valid;
   logic [15:0] dec_instr;
   logic [15:0] dec_pc;
   logic [15:0] dec_pc_plus2;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_address (imem_address),
      .imem_read    (imem_read),
      .imem_resp    (imem_resp),
      .imem_rdata   (imem_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .dec_ready    (dec_ready),
      .dec_valid    (dec_valid),
      .dec_instr    (dec_instr),
      .dec_pc       (dec_pc),
      .dec_pc_plus2 (dec_pc_plus2)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];          // pcs decode should see, oldest first
   logic [15:0] exp_req;           // address of the next new request
   logic [15:0] req_seen;          // address of the request in flight
   bit          outstanding = 0;
   bit          stale       = 0;   // in-flight request predates a redirect
   int          wait_cnt    = 0;
   int          lat         = 0;
   int          lat_fixed   = 2;   // negative selects random latency
   int          post_reset  = 1;
   bit          resume_due  = 0;
   int          idle_run    = 0;
   bit          last_redir  = 0;

   function automatic logic [15:0] word_at(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs at the falling edge, run the memory
   // model, drive inputs for the next rising edge, update the reference.
   // rmode: 0 no redirect, 1 redirect, 2 redirect only if memory responds.
   task automatic cycle(input logic rdy, input int rmode, input logic [15:0] tgt,
                        input logic rst_in);
      logic        resp;
      logic        redir;
      logic        pop;
      logic        push;
      logic [15:0] tgtw;
      @(negedge clk);

      if (post_reset == 1) begin
         chk("rst_imem_read", 16'(imem_read), 16'd0);
         chk("rst_dec_valid", 16'(dec_valid), 16'd0);
         chk("rst_dec_instr", dec_instr, 16'd0);
         chk("rst_dec_pc", dec_pc, 16'd0);
         chk("rst_dec_pc_plus2", dec_pc_plus2, 16'd2);
         chk("rst_imem_address", imem_address, RST_PC);
         post_reset = 2;
      end else if (post_reset == 2) begin
         chk("first_request", 16'(imem_read), 16'd1);
         post_reset = 0;
      end

      chk("dec_valid", 16'(dec_valid), 16'(exp_q.size() != 0));
      if (dec_valid === 1'b1 && exp_q.size() != 0) begin
         chk("dec_pc", dec_pc, exp_q[0]);
         chk("dec_instr", dec_instr, word_at(exp_q[0]));
         chk("dec_pc_plus2", dec_pc_plus2, exp_q[0] + 16'd2);
      end
      chk("addr_bit0", 16'(imem_address[0]), 16'd0);
      if (exp_q.size() == 2) chk("read_when_full", 16'(imem_read), 16'd0);
      if (resume_due) chk("resume_after_pop", 16'(imem_read), 16'd1);
      resume_due = 0;

      if (imem_read !== 1'b1 && exp_q.size() < 2) idle_run++;
      else idle_run = 0;
      if (idle_run > 3) begin
         chk("fetch_stall", 16'(idle_run), 16'd3);
         idle_run = 0;
      end

      resp = 1'b0;
      if (!rst_in) begin
         if (imem_read === 1'b1) begin
            if (!outstanding) begin
               chk("req_addr", imem_address, exp_req);
               outstanding = 1;
               req_seen    = imem_address;
               wait_cnt    = 0;
               lat         = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
               exp_req     = exp_req + 16'd2;
            end else begin
               chk("req_addr_stable", imem_address, req_seen);
            end
            resp = (wait_cnt >= lat);
            wait_cnt++;
         end else if (outstanding) begin
            chk("req_abandoned", 16'(imem_read), 16'd1);
            outstanding = 0;
         end
      end

      redir       = (rmode == 1) || (rmode == 2 && resp);
      last_redir  = redir;
      rst         = rst_in;
      dec_ready   = rdy;
      redirect    = redir;
      redirect_pc = tgt;
      imem_resp   = resp;
      imem_rdata  = resp ? word_at(imem_address) : 16'($urandom);

      if (rst_in) begin
         exp_q.delete();
         exp_req     = RST_PC;
         outstanding = 0;
         stale       = 0;
         post_reset  = 1;
         idle_run    = 0;
         return;
      end

      pop  = (exp_q.size() != 0) && rdy && !redir;
      push = resp && !redir && !stale;
      resume_due = (exp_q.size() == 2) && pop;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
         if (exp_q.size() >= 2) chk("fifo_overflow", 16'(exp_q.size()), 16'd1);
         exp_q.push_back(req_seen);
      end
      if (resp) begin
         outstanding = 0;
         stale       = 0;
      end
      if (redir) begin
         tgtw = tgt & 16'hFFFE;
         exp_q.delete();
         exp_req  = tgtw;
         if (outstanding) stale = 1;
         idle_run = 0;
         if (post_reset == 2) post_reset = 0;
      end
   endtask

   // Run until a live request has waited at least one cycle.
   task automatic wait_pending(input logic rdy);
      int budget = 40;
      while (!(outstanding && !stale && wait_cnt >= 1) && budget > 0) begin
         cycle(rdy, 0, 16'h0, 1'b0);
         budget--;
      end
      if (budget == 0) chk("wait_pending_budget", 16'(budget), 16'd1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int budget;
      rst = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
      imem_resp = 1'b0; imem_rdata = 16'h0;
      exp_req = RST_PC;
      @(posedge clk);
      cycle(1'b1, 0, 16'h0, 1'b1);

      // In-order stream from RESET_PC, 2-cycle memory, decode always ready.
      lat_fixed = 2;
      repeat (20) cycle(1'b1, 0, 16'h0, 1'b0);

      // Decode stalls: buffer fills to two, fetch stops, then resumes.
      repeat (10) cycle(1'b0, 0, 16'h0, 1'b0);
      chk("full_after_stall", 16'(exp_q.size()), 16'd2);
      repeat (12) cycle(1'b1, 0, 16'h0, 1'b0);

      // Redirect while a request is pending: old request drained, not used.
      lat_fixed = 5;
      wait_pending(1'b1);
      cycle(1'b1, 1, 16'h4000, 1'b0);
      repeat (20) cycle(1'b1, 0, 16'h0, 1'b0);

      // Redirect coinciding with a response while a word is buffered.
      lat_fixed = 2;
      budget = 30;
      while (!(exp_q.size() >= 1 && outstanding && !stale) && budget > 0) begin
         cycle(1'b0, 0, 16'h0, 1'b0);
         budget--;
      end
      last_redir = 0;
      while (!last_redir && budget > 0) begin
         cycle(1'b1, 2, 16'h5000, 1'b0);
         budget--;
      end
      chk("redir_with_resp_seen", 16'(last_redir), 16'd1);
      repeat (12) cycle(1'b1, 0, 16'h0, 1'b0);

      // Address wrap and odd redirect target.
      lat_fixed = 1;
      cycle(1'b1, 1, 16'hFFFC, 1'b0);
      repeat (16) cycle(1'b1, 0, 16'h0, 1'b0);
      cycle(1'b1, 1, 16'h1235, 1'b0);
      repeat (10) cycle(1'b1, 0, 16'h0, 1'b0);

      // Random traffic: latency, decode stalls, redirects.
      lat_fixed = -1;
      for (int i = 0; i < 400; i++) begin
         int r;
         int rm;
         r  = int'($urandom_range(0, 39));
         rm = (r < 2) ? 1 : ((r < 4) ? 2 : 0);
         cycle($urandom_range(0, 3) != 0, rm, 16'($urandom), 1'b0);
      end
      repeat (8) cycle(1'b1, 0, 16'h0, 1'b0);

      // Reset while draining a redirected request.
      lat_fixed = 6;
      wait_pending(1'b1);
      cycle(1'b1, 1, 16'h7000, 1'b0);
      cycle(1'b1, 0, 16'h0, 1'b0);
      cycle(1'b1, 0, 16'h0, 1'b1);
      lat_fixed = 1;
      repeat (12) cycle(1'b1, 0, 16'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
